div_seq: RTL and testbench



---
 rtl/fpu_div_pkg.sv | 17 +
 rtl/div_step.sv | 22 ++
 rtl/div_seq.sv | 127 ++++++++++++
 tb/tb_div_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package fpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // The iteration counter must be able to hold WIDTH itself.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit and
// subtract the divisor when the partial remainder is large enough.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;

  // The shifted remainder needs WIDTH+1 bits so large divisors compare correctly.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, div_i});
    rem_o   = q_o ? (shifted[WIDTH-1:0] - div_i) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider, result packed as {remainder, quotient}.
// Define DIV_SIGNED_EN to add the sgn input for two's-complement division.
module div_seq
  import fpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef DIV_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y
);

  localparam int CW = div_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  div_state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               negQuo_q, negQuo_d;
  logic               negRem_q, negRem_d;

  logic               signedOp;
  logic [WIDTH-1:0]   stepRem;
  logic               stepBit;
  logic [WIDTH-1:0]   finalQuo;
  logic [WIDTH-1:0]   finalRem;

`ifdef DIV_SIGNED_EN
  assign signedOp = sgn;
`else
  assign signedOp = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[WIDTH-1]),
    .div_i (div_q),
    .rem_o (stepRem),
    .q_o   (stepBit)
  );

  // A zero divisor keeps the all-ones quotient unnegated so signed x/0 yields -1.
  assign finalQuo = (negQuo_q && (div_q != '0)) ? -quo_q : quo_q;
  assign finalRem = negRem_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      y_q      <= '0;
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      y_q      <= y_d;
      negQuo_q <= negQuo_d;
      negRem_q <= negRem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    y_d       = y_q;
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          quo_d    = (signedOp && a[WIDTH-1]) ? -a : a;
          div_d    = (signedOp && b[WIDTH-1]) ? -b : b;
          rem_d    = '0;
          cnt_d    = '0;
          negQuo_d = signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
          negRem_d = signedOp && a[WIDTH-1];
          state_d  = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // The final RUN cycle applies the sign fix-up and publishes the result.
        if (cnt_q == LAST_CNT) begin
          y_d     = {finalRem, finalQuo};
          state_d = DONE;
        end else begin
          rem_d = stepRem;
          quo_d = {quo_q[WIDTH-2:0], stepBit};
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign y = y_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; signed cases build with DIV_SIGNED_EN.
module tb_div_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] y;
`ifdef DIV_SIGNED_EN
  logic           sgn = 1'b0;
`endif

  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef DIV_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges counted from the accept edge until out_valid is seen, capped at 100.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    assertCount++;
    if (in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    assertCount++;
    if (out_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    assertCount++;
    if (y !== 64'd0) begin
      failCount++;
      $display("[TB] FAIL reset_y: got %h expected 0", y);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    start_op(32'd100, 32'd7);
    wait_result(lat);
    assertCount++;
    if (lat !== 33) begin
      failCount++;
      $display("[TB] FAIL basic_latency: got %0d expected 33", lat);
    end
    assertCount++;
    if (y !== {32'd2, 32'd14}) begin
      failCount++;
      $display("[TB] FAIL basic_y: got %h expected %h", y, {32'd2, 32'd14});
    end
    @(posedge clk);
    #1;
    assertCount++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL basic_release: got ready/valid %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0]   opA [3];
    logic [W-1:0]   opB [3];
    logic [2*W-1:0] exp [3];
    int lat;
    opA[0] = 32'hFFFFFFFF; opB[0] = 32'd1;        exp[0] = {32'd0, 32'hFFFFFFFF};
    opA[1] = 32'd5;        opB[1] = 32'hFFFFFFFF; exp[1] = {32'd5, 32'd0};
    opA[2] = 32'hFFFFFFFF; opB[2] = 32'h80000001; exp[2] = {32'h7FFFFFFE, 32'd1};
    for (int i = 0; i < 3; i++) begin
      start_op(opA[i], opB[i]);
      wait_result(lat);
      assertCount++;
      if (y !== exp[i]) begin
        failCount++;
        $display("[TB] FAIL extremes_y[%0d]: got %h expected %h", i, y, exp[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(32'd1234, 32'd0);
    wait_result(lat);
    assertCount++;
    if (lat !== 33) begin
      failCount++;
      $display("[TB] FAIL divzero_latency: got %0d expected 33", lat);
    end
    assertCount++;
    if (y !== {32'd1234, 32'hFFFFFFFF}) begin
      failCount++;
      $display("[TB] FAIL divzero_y: got %h expected %h", y, {32'd1234, 32'hFFFFFFFF});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start_op(32'd20, 32'd3);
    wait_result(lat);
    assertCount++;
    if (lat !== 33) begin
      failCount++;
      $display("[TB] FAIL stall_latency: got %0d expected 33", lat);
    end
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      in_valid = i[0];
      @(posedge clk);
      #1;
      assertCount++;
      if (y !== {32'd2, 32'd6}) begin
        failCount++;
        $display("[TB] FAIL stall_y[%0d]: got %h expected %h", i, y, {32'd2, 32'd6});
      end
      assertCount++;
      if ({in_ready, out_valid} !== 2'b01) begin
        failCount++;
        $display("[TB] FAIL stall_ctrl[%0d]: got ready/valid %b expected 01", i, {in_ready, out_valid});
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    assertCount++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL stall_release: got ready/valid %b expected 10", {in_ready, out_valid});
    end
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL stall_no_reaccept: got ready/valid %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    assertCount++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL midreset_ctrl: got ready/valid %b expected 10", {in_ready, out_valid});
    end
    assertCount++;
    if (y !== 64'd0) begin
      failCount++;
      $display("[TB] FAIL midreset_y: got %h expected 0", y);
    end
    start_op(32'd9, 32'd2);
    wait_result(lat);
    assertCount++;
    if (y !== {32'd1, 32'd4}) begin
      failCount++;
      $display("[TB] FAIL midreset_fresh_y: got %h expected %h", y, {32'd1, 32'd4});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    a = 32'd50;
    b = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd51;
    wait_result(lat);
    assertCount++;
    if (y !== {32'd0, 32'd10}) begin
      failCount++;
      $display("[TB] FAIL b2b_first_y: got %h expected %h", y, {32'd0, 32'd10});
    end
    wait_result(lat);
    in_valid = 1'b0;
    assertCount++;
    if (y !== {32'd1, 32'd10}) begin
      failCount++;
      $display("[TB] FAIL b2b_second_y: got %h expected %h", y, {32'd1, 32'd10});
    end
    @(posedge clk);
    #1;
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0]   opA [4];
    logic [W-1:0]   opB [4];
    logic           opS [4];
    logic [2*W-1:0] exp [4];
    int lat;
    opA[0] = 32'hFFFFFFF9; opB[0] = 32'd2;        opS[0] = 1'b1; exp[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
    opA[1] = 32'h80000000; opB[1] = 32'hFFFFFFFF; opS[1] = 1'b1; exp[1] = {32'd0, 32'h80000000};
    opA[2] = 32'hFFFFFFFB; opB[2] = 32'd0;        opS[2] = 1'b1; exp[2] = {32'hFFFFFFFB, 32'hFFFFFFFF};
    opA[3] = 32'hFFFFFFF9; opB[3] = 32'd2;        opS[3] = 1'b0; exp[3] = {32'd1, 32'h7FFFFFFC};
    for (int i = 0; i < 4; i++) begin
      sgn = opS[i];
      start_op(opA[i], opB[i]);
      sgn = 1'b0;
      wait_result(lat);
      assertCount++;
      if (y !== exp[i]) begin
        failCount++;
        $display("[TB] FAIL signed_y[%0d]: got %h expected %h", i, y, exp[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
